// File: rtl/c1_bus_pkg.sv
// rtl/c1_bus_pkg.sv - shared C1 bus command codes, widths and size helpers
package c1_bus_pkg;

    localparam int C1_ADDR_W       = 5;
    localparam int C1_DATA_W       = 16;
    localparam int C1_CTRL_W       = 4;
    localparam int CACHE_LINE_SIZE = 16;

    typedef enum logic [3:0] {
        C1_NOP        = 4'd0,
        C1_READ8      = 4'd1,
        C1_READ16     = 4'd2,
        C1_READ32     = 4'd3,
        C1_INVALIDATE = 4'd4,
        C1_WRITE8     = 4'd5,
        C1_WRITE16    = 4'd6,
        C1_WRITE32    = 4'd7
    } c1_cmd_e;

    localparam logic [3:0] C1_RESPONSE = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } c1_state_e;

    // Access size in bits; zero for commands that move no data.
    function automatic int size_bits(input c1_cmd_e cmd);
        case (cmd)
            C1_READ8,  C1_WRITE8:  return 8;
            C1_READ16, C1_WRITE16: return 16;
            C1_READ32, C1_WRITE32: return 32;
            default:               return 0;
        endcase
    endfunction

    function automatic logic is_read(input c1_cmd_e cmd);
        return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
    endfunction

    function automatic logic is_write(input c1_cmd_e cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

endpackage

// File: rtl/c1_byte_mem.sv
// rtl/c1_byte_mem.sv - byte-addressed store with wrapping multi-byte read and byte-enable write
module c1_byte_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [DATA_W/8-1:0]   wr_be_i
);
    localparam int MEM_BYTES = 2 ** ADDR_W;
    localparam int NB        = DATA_W / 8;

    logic [7:0] mem_q [MEM_BYTES];

    // Address arithmetic is ADDR_W wide, so a+i wraps around the array for free.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NB; i++) begin
            rd_data_o[8*i +: 8] = mem_q[rd_addr_i + ADDR_W'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < MEM_BYTES; j++) begin
                mem_q[j] <= 8'hFF;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_i[i]) begin
                    mem_q[wr_addr_i + ADDR_W'(i)] <= wr_data_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/c1_bus_responder.sv
// rtl/c1_bus_responder.sv - memory-side C1 bus responder with multi-beat transfers and latency
module c1_bus_responder
    import c1_bus_pkg::*;
#(
    parameter int ADDR_W  = C1_ADDR_W,
    parameter int DATA_W  = C1_DATA_W,
    parameter int CTRL_W  = C1_CTRL_W,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a1,
    input  logic [CTRL_W-1:0] c1_in,
    input  logic [DATA_W-1:0] d1_in,
    output logic [CTRL_W-1:0] c1_out,
    output logic [DATA_W-1:0] d1_out,
    output logic              drive_en,
    output logic              busy
);
    localparam int NB    = DATA_W / 8;
    localparam int LAT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    c1_state_e         state_q, state_d;
    c1_cmd_e           cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              drive_en_q, drive_en_d;
    logic [CTRL_W-1:0] c1_out_q, c1_out_d;
    logic [DATA_W-1:0] d1_out_q, d1_out_d;

    c1_cmd_e           cmd_in;
    logic              cmd_legal, last_resp, wr_en;
    logic [NB-1:0]     wr_be;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] rd_data;

    function automatic logic [2:0] beats_of(input c1_cmd_e c);
        int n;
        n = size_bits(c) / DATA_W;
        return (n < 1) ? 3'd1 : 3'(n);
    endfunction

    function automatic logic [2:0] resp_beats(input c1_cmd_e c);
        return is_read(c) ? beats_of(c) : 3'd1;
    endfunction

    // Narrow reads on a wide bus zero the unused upper lanes.
    function automatic logic [DATA_W-1:0] beat_mask(input c1_cmd_e c);
        int sb;
        sb = size_bits(c);
        return (sb >= DATA_W) ? '1 : DATA_W'((64'd1 << sb) - 64'd1);
    endfunction

    assign cmd_in    = c1_cmd_e'(c1_in[3:0]);
    assign cmd_legal = (c1_in != '0) && (c1_in < CTRL_W'(8));
    assign last_resp = (beat_q == resp_beats(cmd_q) - 3'd1);
    assign wr_en     = (state_q == ST_WDATA);
    assign wr_addr   = addr_q + ADDR_W'(beat_q * NB);
    assign rd_addr   = addr_q + ADDR_W'(beat_d * NB);

    always_comb begin
        wr_be = '0;
        for (int i = 0; i < NB; i++) begin
            wr_be[i] = (i * 8) < size_bits(cmd_q);
        end
    end

    c1_byte_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (d1_in),
        .wr_be_i   (wr_be)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= C1_NOP;
            addr_q     <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            drive_en_q <= 1'b0;
            c1_out_q   <= '0;
            d1_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            drive_en_q <= drive_en_d;
            c1_out_q   <= c1_out_d;
            d1_out_q   <= d1_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        case (state_q)
            ST_WDATA: begin
                if (beat_q == beats_of(cmd_q) - 3'd1) begin
                    state_d = ST_WAIT;
                    beat_d  = '0;
                    lat_d   = LAT_W'(LATENCY);
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (last_resp) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            default: ;
        endcase
        // A new command may land on the edge that retires the final response beat.
        if (((state_q == ST_IDLE) || ((state_q == ST_RESP) && last_resp)) && cmd_legal) begin
            cmd_d   = cmd_in;
            addr_d  = a1;
            beat_d  = '0;
            lat_d   = LAT_W'(LATENCY);
            state_d = is_write(cmd_in) ? ST_WDATA : ST_WAIT;
        end
    end

    always_comb begin
        drive_en_d = (state_d == ST_RESP);
        c1_out_d   = drive_en_d ? CTRL_W'(C1_RESPONSE) : '0;
        d1_out_d   = (drive_en_d && is_read(cmd_q)) ? (rd_data & beat_mask(cmd_q)) : '0;
    end

    assign drive_en = drive_en_q;
    assign c1_out   = c1_out_q;
    assign d1_out   = d1_out_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_c1_bus_responder.sv
// tb/tb_c1_bus_responder.sv - directed vector bench for c1_bus_responder
module tb_c1_bus_responder;

    typedef struct {
        logic        rst;
        logic [4:0]  a;
        logic [3:0]  c;
        logic [15:0] d;
        logic        de;
        logic [3:0]  co;
        logic [15:0] dout;
        logic        busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  a1 = '0, a2 = '0;
    logic [3:0]  c1_in = '0, c2_in = '0;
    logic [15:0] d1_in = '0;
    logic [31:0] d2_in = '0;
    logic [3:0]  c1_out, c2_out;
    logic [15:0] d1_out;
    logic [31:0] d2_out;
    logic        de1, de2, busy1, busy2;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    c1_bus_responder #(.ADDR_W(5), .DATA_W(16), .CTRL_W(4), .LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .c1_in(c1_in), .d1_in(d1_in),
        .c1_out(c1_out), .d1_out(d1_out), .drive_en(de1), .busy(busy1)
    );

    c1_bus_responder #(.ADDR_W(5), .DATA_W(32), .CTRL_W(4), .LATENCY(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .a1(a2), .c1_in(c2_in), .d1_in(d2_in),
        .c1_out(c2_out), .d1_out(d2_out), .drive_en(de2), .busy(busy2)
    );

    function automatic vec_t mk(input logic rst, input logic [4:0] a, input logic [3:0] c,
                                input logic [15:0] d, input logic de, input logic [3:0] co,
                                input logic [15:0] dout, input logic busy);
        vec_t v;
        v.rst = rst; v.a = a; v.c = c; v.d = d;
        v.de = de; v.co = co; v.dout = dout; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic ade, input logic [3:0] ac, input logic [31:0] ad,
                       input logic ab, input logic ede, input logic [3:0] ec, input logic [31:0] ed,
                       input logic eb);
        n_vec++;
        if (ade !== ede || ac !== ec || ad !== ed || ab !== eb) begin
            n_miss++;
            $display("FAIL %s: got de=%b c1=%h d1=%h busy=%b, want de=%b c1=%h d1=%h busy=%b",
                     nm, ade, ac, ad, ab, ede, ec, ed, eb);
        end
    endtask

    task automatic chk1(input string nm, input logic ede, input logic [3:0] ec,
                        input logic [15:0] ed, input logic eb);
        chk(nm, de1, c1_out, {16'h0, d1_out}, busy1, ede, ec, {16'h0, ed}, eb);
    endtask

    task automatic chk2(input string nm, input logic ede, input logic [3:0] ec,
                        input logic [31:0] ed, input logic eb);
        chk(nm, de2, c2_out, d2_out, busy2, ede, ec, ed, eb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inputs before edge k, outputs expected just after edge k
        tv.push_back(mk(0,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  0, 1, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h00FF, 1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  3, 6, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'hBEEF, 0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  3, 2, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'hBEEF, 1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  4, 1, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h00BE, 1));
        tv.push_back(mk(1,  3, 1, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h00EF, 1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1, 30, 7, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h5678, 0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h1234, 0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1, 30, 3, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h5678, 1));
        tv.push_back(mk(1,  5, 1, 16'h0,    1, 1, 16'h1234, 1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  0, 2, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h1234, 1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  0, 1, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 5, 16'h0,    1, 1, 16'h0034, 1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  0, 9, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  0, 4, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));
        tv.push_back(mk(1,  0, 2, 16'h0,    0, 0, 16'h0,    1));
        tv.push_back(mk(1,  0, 0, 16'h0,    1, 1, 16'h1234, 1));
        tv.push_back(mk(1,  0, 0, 16'h0,    0, 0, 16'h0,    0));

        foreach (tv[i]) begin
            rst_n = tv[i].rst; a1 = tv[i].a; c1_in = tv[i].c; d1_in = tv[i].d;
            tick();
            chk1($sformatf("vec%0d", i), tv[i].de, tv[i].co, tv[i].dout, tv[i].busy);
        end

        // reset asserted while the second READ32 beat is on the bus
        a1 = 5'd30; c1_in = 4'd3; tick();
        c1_in = 4'd0; chk1("r32_wait", 0, 0, 16'h0, 1);
        tick(); chk1("r32_beat0", 1, 1, 16'h5678, 1);
        tick(); chk1("r32_beat1", 1, 1, 16'h1234, 1);
        #2 rst_n = 1'b0;
        #1 chk1("async_reset", 0, 0, 16'h0, 0);
        tick(); rst_n = 1'b1;
        a1 = 5'd30; c1_in = 4'd3; tick();
        c1_in = 4'd0; tick(); chk1("post_rst_beat0", 1, 1, 16'hFFFF, 1);
        tick(); chk1("post_rst_beat1", 1, 1, 16'hFFFF, 1);
        tick(); chk1("post_rst_idle", 0, 0, 16'h0, 0);

        // LATENCY=3, DATA_W=32 instance
        a2 = 5'd0; c2_in = 4'd3; tick();
        c2_in = 4'd0; chk2("l3_r32_wait0", 0, 0, 32'h0, 1);
        tick(); tick(); chk2("l3_r32_wait2", 0, 0, 32'h0, 1);
        tick(); chk2("l3_r32_beat", 1, 1, 32'hFFFF_FFFF, 1);
        tick(); chk2("l3_r32_idle", 0, 0, 32'h0, 0);

        a2 = 5'd2; c2_in = 4'd5; d2_in = 32'h0000_00A5; tick();
        c2_in = 4'd0; tick();
        d2_in = 32'h0; tick(); tick(); chk2("l3_w8_wait", 0, 0, 32'h0, 1);
        tick(); chk2("l3_w8_resp", 1, 1, 32'h0, 1);
        tick(); chk2("l3_w8_idle", 0, 0, 32'h0, 0);

        a2 = 5'd2; c2_in = 4'd1; tick();
        c2_in = 4'd0; tick(); tick(); tick(); chk2("l3_r8_beat", 1, 1, 32'h0000_00A5, 1);
        tick(); chk2("l3_r8_idle", 0, 0, 32'h0, 0);

        a2 = 5'd0; c2_in = 4'd3; tick();
        c2_in = 4'd0; tick(); tick(); tick(); chk2("l3_r32_merge", 1, 1, 32'hFFA5_FFFF, 1);
        tick(); chk2("l3_r32_end", 0, 0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/c1_bus_responder.md
Name: c1_bus_responder

Overview:
Parametrised memory-side responder for the C1 CPU-to-cache bus. It replaces the single-command READ8 responder. It implements the full C1 command set (READ8/16/32, WRITE8/16/32, INVALIDATE_LINE) with multi-beat transfers when the access is wider than the data bus, plus a configurable response latency. It sits on the cache side of the C1 bus. The top level builds the shared tristate d1/c1 nets from the split in/out/drive_en ports.

Parameters:
ADDR_W, 5, byte-address width; memory holds MEM_BYTES = 2**ADDR_W bytes
DATA_W, 16, d1 width; legal values 8, 16, 32
CTRL_W, 4, c1 width
LATENCY, 1, idle cycles between the end of the request and the first response beat; minimum 1 (bus turnaround)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
a1  in  ADDR_W  byte address, sampled with the command
c1_in  in  CTRL_W  command from CPU
d1_in  in  DATA_W  write data from CPU
c1_out  out  CTRL_W  response code while driving
d1_out  out  DATA_W  read data while driving
drive_en  out  1  responder owns d1/c1 this cycle
busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release): state IDLE; drive_en=0, c1_out=0, d1_out=0, busy=0; every memory byte set to 8'hFF. Reset mid-transaction aborts it; drive_en drops immediately.
- Command codes: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7. RESPONSE=1. Codes 8..15 are ignored; the block stays in IDLE.
- Sizes: 8/16/32 bits. BEATS = max(1, size/DATA_W).
- Byte order is little-endian. The byte at address a goes in d1[7:0] of the first beat, a+1 in d1[15:8], and so on. Beat n carries bytes a+n*DATA_W/8 upward. Unused upper bits read as 0.
- All addresses a+i wrap modulo MEM_BYTES. No alignment requirement.
- State machine:
  - IDLE: at a posedge with c1_in a legal non-NOP command, capture a1 and the command.
    - Write command -> WDATA.
    - Read or INVALIDATE with LATENCY counter = LATENCY -> WAIT.
  - WDATA: sample d1_in on each of the next BEATS posedges (E+1..E+BEATS) and commit bytes to memory on each edge. After the last beat -> WAIT.
  - WAIT: count LATENCY cycles with drive_en=0. On expiry -> RESP.
  - RESP: drive_en=1, c1_out=RESPONSE.
    - Reads: BEATS cycles, d1_out = beat data.
    - Writes/INVALIDATE: 1 cycle, d1_out=0.
    - Then -> IDLE with drive_en=0, c1_out=0, d1_out=0.
- Timing for a command sampled at edge E: the CPU samples read beat n (n from 0) at edge E+LATENCY+1+n. For writes, it samples the response at E+BEATS+LATENCY+1.
- Commands arriving while busy=1 are ignored; no queueing.
- The next command is accepted on the edge where the CPU samples the last response beat.
- INVALIDATE_LINE leaves memory unchanged; it only produces a response.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package c1_bus_pkg holds:
  - command enum c1_cmd_e and C1_RESPONSE
  - default ADDR/DATA/CTRL widths and CACHE_LINE_SIZE
  - function size_bits(cmd)
- Sub-module c1_byte_mem: byte-addressed storage with wrap-around multi-byte read port, byte-enable write port, and reset fill to 8'hFF.
- The FSM and beat counter stay in c1_bus_responder.

Test Plan:
All scenarios use default parameters unless stated.
- Reset then READ8 a1=0 at edge E -> at E+2: drive_en=1, c1_out=1, d1_out=16'h00FF. At E+3: drive_en=0. Before E+1: busy=0, all outputs 0.
- WRITE16 a1=3, data 16'hBEEF at E+1 -> response at E+3. Then READ16 a1=3 -> 16'hBEEF. READ8 a1=4 -> 16'h00BE.
- WRITE32 a1=30, beats 16'h5678 then 16'h1234 -> bytes 30=78, 31=56, 0=34, 1=12 (wrap). READ32 a1=30 -> beats 16'h5678, 16'h1234 on consecutive edges, with drive_en held for 2 cycles.
- READ8 issued while busy and code 9 in IDLE -> both ignored: no extra response, memory unchanged. INVALIDATE_LINE -> single response at E+2 with d1_out=0, memory unchanged.
- rst_n pulsed low during the second READ32 beat -> drive_en=0 asynchronously, busy=0, memory reads back 8'hFF.
- LATENCY=3, DATA_W=32: READ32 a1=0 -> single beat 32'hFFFFFFFF sampled at E+4. WRITE8 a1=2 of 8'hA5 -> response at E+5, and READ8 a1=2 returns 8'hA5.
